// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher. It walks a fetch pointer through program
// memory with a single-outstanding request/ack port and buffers the returned
// words in a DEPTH-entry queue that presents {instr, pc, pc+1} at its head.
// Ports: clk/rst (async active-low); redirect/redirect_pc flush and retarget;
//        stall holds the queue head; imem_req/imem_addr/imem_ack/imem_data form
//        the memory port; out_valid/out_instr/out_pc/out_pc1/q_count describe the queue.
// Latency: first instruction appears three cycles after reset release or after a
//          redirect target is issued; steady state is one instruction per cycle.
// Backpressure: stall freezes the head; a request is only issued when its response
//               is guaranteed a free slot.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc1,
  output logic [3:0]  q_count
);

  localparam int         AW      = (DEPTH <= 2) ? 1 : (DEPTH <= 4) ? 2 : 3;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fpc;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [3:0]    r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic [1:0]  w_state_nxt;
  logic [31:0] w_fpc_nxt;
  logic        w_req_nxt;
  logic [31:0] w_addr_nxt;
  logic [3:0]  w_count_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_space;
  logic [31:0] w_addr_inc;
  logic [31:0] w_head_pc;

  // Redirect wins over everything: no pop, no push, queue emptied.
  assign w_pop       = (r_count != 4'd0) && !stall && !redirect;
  assign w_push      = (r_state == S_WAIT) && imem_ack && !redirect;
  assign w_count_nxt = redirect ? 4'd0 : (r_count + {3'd0, w_push} - {3'd0, w_pop});
  // A new request may be in flight next cycle only if its response could be
  // pushed even when nothing is popped that cycle.
  assign w_space     = (w_count_nxt < DEPTH_C);
  assign w_addr_inc  = r_addr + 32'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    if (redirect) begin
      w_fpc_nxt = redirect_pc;
    end
    case (r_state)
      S_IDLE: begin
        if (!redirect && w_space) begin
          w_state_nxt = S_WAIT;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fpc;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // An in-flight request cannot be withdrawn; its response is swallowed in DROP.
          if (imem_ack) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (imem_ack) begin
          w_fpc_nxt = w_addr_inc;
          if (w_space) begin
            w_addr_nxt = w_addr_inc;
          end else begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_fpc    <= RESET_PC;
      r_req    <= 1'b0;
      r_addr   <= 32'd0;
      r_count  <= 4'd0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Queue storage needs no reset: the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= imem_data;
      r_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign w_head_pc = r_pc[r_rd_ptr];

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign q_count   = r_count;
  assign out_valid = (r_count != 4'd0);
  assign out_instr = out_valid ? r_instr[r_rd_ptr] : 32'd0;
  assign out_pc    = out_valid ? w_head_pc : 32'd0;
  assign out_pc1   = out_valid ? (w_head_pc + 32'd1) : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run of fetch_unit against
// a memory model and an in-order program-counter reference.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc1;
  logic [3:0]  q_count;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc1(out_pc1),
    .q_count(q_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Program memory: contents are a fixed hash of the word address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Memory answers a request that was already up in the previous cycle, gated
  // by a per-cycle random acceptance; the address is held until ack, so data
  // is read from the current address.
  int   ack_pct   = 100;
  logic m_prev    = 1'b0;
  logic m_gate    = 1'b0;
  logic force_ack = 1'b0;

  always @(posedge clk) begin
    m_prev <= imem_req;
    m_gate <= (int'($urandom_range(0, 99)) < ack_pct);
  end

  assign imem_ack  = (imem_req && m_prev && m_gate) || force_ack;
  assign imem_data = mem_fn(imem_addr);

  // Reference: instructions leave in strict address order starting at the reset
  // PC or the latest redirect target; a redirect empties the queue.
  logic [31:0] exp_pc   = RESET_PC;
  logic        exp_flush = 1'b0;
  logic        prv_req  = 1'b0;
  logic        prv_ack  = 1'b0;
  logic [31:0] prv_addr = 32'd0;
  int          n_pops   = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_pc    = RESET_PC;
      exp_flush = 1'b0;
      prv_req   = 1'b0;
      prv_ack   = 1'b0;
      prv_addr  = 32'd0;
    end else begin
      chk("valid_vs_count", 32'(out_valid), 32'(q_count != 4'd0));
      chk("count_max", 32'(q_count <= 4'(DEPTH)), 32'd1);
      if (exp_flush) chk("flush_valid", 32'(out_valid), 32'd0);
      if (prv_req && !prv_ack) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, prv_addr);
      end
      if (out_valid && !stall && !redirect) begin
        chk("pop_pc", out_pc, exp_pc);
        chk("pop_instr", out_instr, mem_fn(exp_pc));
        chk("pop_pc1", out_pc1, exp_pc + 32'd1);
        exp_pc = exp_pc + 32'd1;
        n_pops++;
      end
      if (redirect) exp_pc = redirect_pc;
      exp_flush = redirect;
      prv_req   = imem_req;
      prv_ack   = imem_ack;
      prv_addr  = imem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] got_pc  [0:7];
  logic [31:0] got_pc1 [0:7];
  int          got_n;
  int          lat;
  logic        seen;
  logic [31:0] old_addr;
  int          stall_pct;
  int          pops_before;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, releases two edges later.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc1", out_pc1, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic collect(input int n);
    got_n = 0;
    for (int i = 0; i < 40 && got_n < n; i++) begin
      @(negedge clk);
      if (out_valid && !stall && !redirect) begin
        got_pc[got_n]  = out_pc;
        got_pc1[got_n] = out_pc1;
        got_n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, then zero-wait streaming with no stall.
    apply_reset();
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("fill_latency", 32'(lat), 32'd3);
    chk("first_pc", out_pc, RESET_PC);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;

    // Reset while waiting with two entries queued; stray ack right after release.
    stall = 1'b1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (q_count == 4'd2) break;
    end
    chk("r37_pre_cnt", 32'(q_count), 32'd2);
    chk("r37_pre_req", 32'(imem_req), 32'd1);
    apply_reset();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;

    // Held stall: queue saturates, requests stop, then drains in order.
    repeat (12) tick();
    chk("r33_full", 32'(q_count), 32'd4);
    chk("r33_req_off", 32'(imem_req), 32'd0);
    repeat (3) tick();
    chk("r33_hold", 32'(q_count), 32'd4);
    stall = 1'b0;
    collect(4);
    chk("r33_drain_n", 32'(got_n), 32'd4);
    for (int i = 0; i < 4; i++) chk("r33_drain_pc", got_pc[i], RESET_PC + 32'(i));

    // Redirect while waiting; the late ack must be discarded.
    repeat (3) tick();
    ack_pct = 0;
    tick();
    tick();
    chk("r34_wait_req", 32'(imem_req), 32'd1);
    chk("r34_no_ack", 32'(imem_ack), 32'd0);
    old_addr    = imem_addr;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("r34_drop_req", 32'(imem_req), 32'd1);
    chk("r34_drop_addr", imem_addr, old_addr);
    tick();
    ack_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("r34_seen", 32'(seen), 32'd1);
    chk("r34_pc", out_pc, 32'h40);
    chk("r34_pc1", out_pc1, 32'h41);
    @(posedge clk);
    #1;

    // Redirect coincident with ack: no push, next request goes to the target.
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_ack) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("r35_ack_found", 32'(seen), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("r35_count", 32'(q_count), 32'd0);
    chk("r35_idle", 32'(imem_req), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("r35_req_seen", 32'(seen), 32'd1);
    chk("r35_addr", imem_addr, 32'h200);

    // Address wrap at the top of the space.
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    collect(4);
    chk("wrap_n", 32'(got_n), 32'd4);
    chk("wrap_pc0", got_pc[0], 32'hFFFF_FFFE);
    chk("wrap_pc1", got_pc[1], 32'hFFFF_FFFF);
    chk("wrap_pc2", got_pc[2], 32'h0000_0000);
    chk("wrap_pc3", got_pc[3], 32'h0000_0001);
    chk("wrap_pc1_of_max", got_pc1[1], 32'h0000_0000);

    // Randomized traffic: stalls, redirects (some near the wrap point), slow memory.
    pops_before = n_pops;
    for (int s = 0; s < 15; s++) begin
      ack_pct   = int'($urandom_range(30, 100));
      stall_pct = int'($urandom_range(0, 60));
      for (int c = 0; c < 200; c++) begin
        stall       = (int'($urandom_range(0, 99)) < stall_pct);
        redirect    = (int'($urandom_range(0, 99)) < 4);
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                  : $urandom;
        tick();
      end
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (4) tick();
    chk("rand_progress", 32'(n_pops - pops_before > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
